// File: rtl/tia_playfield_sequencer.sv
// tia_playfield_sequencer
//
// Horizontal timing and playfield register controller for the TIA.
// Divides the colour clock into 4-phase positions, generates the two-phase
// shift clocks and the rhb/cnt strobes, holds PF0/PF1/PF2/CTRLPF and
// serialises the 20-bit playfield (repeated or reflected in the right half).
//
// Ports:
//   clock    in   colour clock, all state changes on posedge
//   reset    in   synchronous active-high reset
//   rsync    in   restart line: counters to start of line, registers kept
//   wr_en    in   bus write strobe, one clock per write
//   wr_addr  in   0=PF0, 1=PF1, 2=PF2, 3=CTRLPF
//   wr_data  in   write data (PF0 uses [7:4], CTRLPF uses [0]=REF)
//   phase    out  colour-clock phase within position, 0..3
//   pos      out  horizontal position, 0..LINE_POS-1
//   hphi1    out  high when phase==0
//   hphi2    out  high when phase==2
//   rhb      out  high for the whole last HBLANK position
//   cnt      out  high for the whole last left-half position
//   hblank   out  high while pos < HB_END
//   pf       out  serialised playfield pixel
module tia_playfield_sequencer #(
    parameter int LINE_POS   = 57,
    parameter int HB_END     = 17,
    parameter int CENTER_POS = 37
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rsync,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [1:0] phase,
    output logic [5:0] pos,
    output logic       hphi1,
    output logic       hphi2,
    output logic       rhb,
    output logic       cnt,
    output logic       hblank,
    output logic       pf
);

    localparam logic [5:0] LAST_POS = 6'(LINE_POS - 1);
    localparam logic [5:0] HB_POS   = 6'(HB_END);
    localparam logic [5:0] CTR_POS  = 6'(CENTER_POS);
    localparam logic [5:0] RHB_POS  = 6'(HB_END - 1);
    localparam logic [5:0] CNT_POS  = 6'(CENTER_POS - 1);

    logic [3:0]  pf0;
    logic [7:0]  pf1;
    logic [7:0]  pf2;
    logic        ref_bit;
    logic        ref_active;

    logic [5:0]  next_pos;
    logic        load_ref;
    logic        ref_next;
    logic [19:0] pf_bits;
    logic [5:0]  k_wide;
    logic        pf_next;

    assign hphi1 = (phase == 2'd0);
    assign hphi2 = (phase == 2'd2);

    // Next-position decode and playfield bit selection. Everything here is
    // evaluated for the position about to start, so pf/hblank/rhb/cnt can be
    // registered on the phase-3 edge and line up with the new pos exactly.
    // The reflect flag used for the pixel is the value being loaded on this
    // edge at a half-line boundary, so a REF change never splits a half.
    always_comb begin
        next_pos = (pos == LAST_POS) ? 6'd0 : pos + 6'd1;
        load_ref = (next_pos == HB_POS) || (next_pos == CTR_POS);
        ref_next = load_ref ? ref_bit : ref_active;

        // Bit k of pf_bits is playfield bit k: PF0[4..7], PF1[7..0], PF2[0..7].
        pf_bits[3:0]   = pf0;
        pf_bits[11:4]  = {pf1[0], pf1[1], pf1[2], pf1[3],
                          pf1[4], pf1[5], pf1[6], pf1[7]};
        pf_bits[19:12] = pf2;

        k_wide  = 6'd0;
        pf_next = 1'b0;
        if (next_pos >= CTR_POS) begin
            k_wide  = ref_next ? (6'd19 - (next_pos - CTR_POS)) : (next_pos - CTR_POS);
            pf_next = pf_bits[k_wide[4:0]];
        end else if (next_pos >= HB_POS) begin
            k_wide  = next_pos - HB_POS;
            pf_next = pf_bits[k_wide[4:0]];
        end
    end

    // Register writes, counters and the position-aligned outputs. A write and
    // an rsync on the same edge both take effect; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase      <= 2'd0;
            pos        <= 6'd0;
            pf0        <= 4'd0;
            pf1        <= 8'd0;
            pf2        <= 8'd0;
            ref_bit    <= 1'b0;
            ref_active <= 1'b0;
            pf         <= 1'b0;
            hblank     <= 1'b1;
            rhb        <= 1'b0;
            cnt        <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_addr)
                    2'd0: pf0     <= wr_data[7:4];
                    2'd1: pf1     <= wr_data;
                    2'd2: pf2     <= wr_data;
                    2'd3: ref_bit <= wr_data[0];
                endcase
            end
            if (rsync) begin
                phase  <= 2'd0;
                pos    <= 6'd0;
                pf     <= 1'b0;
                hblank <= 1'b1;
                rhb    <= 1'b0;
                cnt    <= 1'b0;
            end else begin
                phase <= phase + 2'd1;
                if (phase == 2'd3) begin
                    pos    <= next_pos;
                    hblank <= (next_pos < HB_POS);
                    rhb    <= (next_pos == RHB_POS);
                    cnt    <= (next_pos == CNT_POS);
                    pf     <= pf_next;
                    if (load_ref) begin
                        ref_active <= ref_bit;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tia_playfield_sequencer.sv
// tb_tia_playfield_sequencer
//
// Self-checking bench for tia_playfield_sequencer. Each scenario task drives
// the bus/rsync/reset inputs clock by clock, pushes the expected output
// vector for the following clock into a queue, and pops and compares it once
// the DUT has produced that clock. Expected vectors come from the line timing
// (228 clocks, 4 per position) and the playfield patterns written.
module tb_tia_playfield_sequencer;

    typedef struct packed {
        logic [1:0] phase;
        logic [5:0] pos;
        logic       hphi1;
        logic       hphi2;
        logic       rhb;
        logic       cnt;
        logic       hblank;
        logic       pf;
    } out_t;

    logic       clock;
    logic       reset;
    logic       rsync;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] phase;
    logic [5:0] pos;
    logic       hphi1;
    logic       hphi2;
    logic       rhb;
    logic       cnt;
    logic       hblank;
    logic       pf;

    out_t obs;
    out_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    tia_playfield_sequencer dut (
        .clock   (clock),
        .reset   (reset),
        .rsync   (rsync),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .phase   (phase),
        .pos     (pos),
        .hphi1   (hphi1),
        .hphi2   (hphi2),
        .rhb     (rhb),
        .cnt     (cnt),
        .hblank  (hblank),
        .pf      (pf)
    );

    assign obs = {phase, pos, hphi1, hphi2, rhb, cnt, hblank, pf};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: bench did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    // Expected outputs for clock c counted from the start of a line.
    function automatic out_t line_exp(input int c, input logic pfv);
        out_t e;
        int   p;
        p        = (c % 228) / 4;
        e.phase  = 2'(c % 4);
        e.pos    = 6'(p);
        e.hphi1  = ((c % 4) == 0);
        e.hphi2  = ((c % 4) == 2);
        e.rhb    = (p == 16);
        e.cnt    = (p == 36);
        e.hblank = (p < 17);
        e.pf     = pfv;
        return e;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset   = 1'b0;
        rsync   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 8'd0;
    endtask

    task automatic set_write(input logic [1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Reset held with a write and rsync pending must win; PF0 stays clear.
    task automatic test_reset();
        out_t e;
        int   p;
        idle();
        reset = 1'b1;
        rsync = 1'b1;
        set_write(2'd0, 8'hFF);
        step();
        step();
        idle();
        exp_q.push_back(line_exp(0, 1'b0));
        for (int c = 0; c <= 72; c++) begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL reset c=%0d actual=%h required=%h", c, obs, e);
            end
            compared++;
            if (c < 72) begin
                idle();
                p = ((c + 1) % 228) / 4;
                exp_q.push_back(line_exp(c + 1, 1'b0));
                step();
            end
        end
    endtask

    // One full line of counter timing with literal clock numbers.
    task automatic test_timing();
        out_t e;
        int   n1;
        int   n2;
        n1 = 0;
        n2 = 0;
        do_reset();
        exp_q.push_back(line_exp(0, 1'b0));
        for (int c = 0; c < 228; c++) begin
            e = exp_q.pop_front();
            e.rhb    = (c >= 64 && c <= 67);
            e.cnt    = (c >= 144 && c <= 147);
            e.hblank = (c < 68);
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL timing c=%0d actual=%h required=%h", c, obs, e);
            end
            compared++;
            if (hphi1) n1++;
            if (hphi2) n2++;
            if (c < 227) begin
                idle();
                exp_q.push_back(line_exp(c + 1, 1'b0));
                step();
            end
        end
        if (n1 !== 57) begin
            mismatched++;
            $display("[TB] FAIL hphi1_count actual=%0d required=57", n1);
        end
        compared++;
        if (n2 !== 57) begin
            mismatched++;
            $display("[TB] FAIL hphi2_count actual=%0d required=57", n2);
        end
        compared++;
    endtask

    // PF0 bit4 and PF2 bit7 repeated: positions 17, 36, 37, 56; then wrap.
    task automatic test_repeat();
        out_t e;
        int   p;
        do_reset();
        exp_q.push_back(line_exp(0, 1'b0));
        for (int c = 0; c <= 240; c++) begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL repeat c=%0d actual=%h required=%h", c, obs, e);
            end
            compared++;
            if (c < 240) begin
                idle();
                case (c)
                    0: set_write(2'd0, 8'h10);
                    1: set_write(2'd1, 8'h00);
                    2: set_write(2'd2, 8'h80);
                    3: set_write(2'd3, 8'h00);
                    default: ;
                endcase
                p = ((c + 1) % 228) / 4;
                exp_q.push_back(line_exp(c + 1, (p == 17 || p == 36 || p == 37 || p == 56)));
                step();
            end
        end
    endtask

    // Only PF0 bit4 set, reflected: positions 17 and 56.
    task automatic test_reflect();
        out_t e;
        int   p;
        do_reset();
        exp_q.push_back(line_exp(0, 1'b0));
        for (int c = 0; c <= 240; c++) begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL reflect c=%0d actual=%h required=%h", c, obs, e);
            end
            compared++;
            if (c < 240) begin
                idle();
                case (c)
                    0: set_write(2'd0, 8'h10);
                    1: set_write(2'd1, 8'h00);
                    2: set_write(2'd2, 8'h00);
                    3: set_write(2'd3, 8'h01);
                    default: ;
                endcase
                p = ((c + 1) % 228) / 4;
                exp_q.push_back(line_exp(c + 1, (p == 17 || p == 56)));
                step();
            end
        end
    endtask

    // REF set at pos 40: this line stays repeated (37, 49), the next line
    // reflects its right half (44, 56). Left half is 17, 29 on both lines.
    task automatic test_ref_midline();
        out_t e;
        int   p;
        logic v;
        do_reset();
        exp_q.push_back(line_exp(0, 1'b0));
        for (int c = 0; c <= 456; c++) begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL ref_midline c=%0d actual=%h required=%h", c, obs, e);
            end
            compared++;
            if (c < 456) begin
                idle();
                case (c)
                    0:   set_write(2'd0, 8'h10);
                    1:   set_write(2'd1, 8'h00);
                    2:   set_write(2'd2, 8'h01);
                    3:   set_write(2'd3, 8'h00);
                    160: set_write(2'd3, 8'h01);
                    default: ;
                endcase
                p = ((c + 1) % 228) / 4;
                if ((c + 1) < 228) v = (p == 17 || p == 29 || p == 37 || p == 49);
                else               v = (p == 17 || p == 29 || p == 44 || p == 56);
                exp_q.push_back(line_exp(c + 1, v));
                step();
            end
        end
    endtask

    // PF1 written on the phase-3 edge ending pos 20: pos 21 still sees 0,
    // then PF1 bits show at 22..28 and at 41..48 in the right half.
    task automatic test_collision();
        out_t e;
        int   p;
        do_reset();
        exp_q.push_back(line_exp(0, 1'b0));
        for (int c = 0; c <= 227; c++) begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL collision c=%0d actual=%h required=%h", c, obs, e);
            end
            compared++;
            if (c < 227) begin
                idle();
                if (c == 83) set_write(2'd1, 8'hFF);
                p = ((c + 1) % 228) / 4;
                exp_q.push_back(line_exp(c + 1, ((p >= 22 && p <= 28) || (p >= 41 && p <= 48))));
                step();
            end
        end
    endtask

    // rsync at pos 30 phase 1 with a PF2 write: restart at pos 0 with pf=0,
    // and the new PF2 pattern appears on the following line.
    task automatic test_rsync();
        out_t       e;
        int         p;
        int         t;
        int         nt;
        logic       after;
        logic       v;
        logic [7:0] pat;
        pat   = 8'h5A;
        t     = 0;
        after = 1'b0;
        do_reset();
        exp_q.push_back(line_exp(0, 1'b0));
        for (int c = 0; c <= 349; c++) begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL rsync c=%0d actual=%h required=%h", c, obs, e);
            end
            compared++;
            if (c < 349) begin
                idle();
                nt = t + 1;
                if (c == 0) set_write(2'd2, 8'hFF);
                if (c == 121) begin
                    rsync = 1'b1;
                    set_write(2'd2, 8'h5A);
                    nt    = 0;
                    after = 1'b1;
                end
                p = (nt % 228) / 4;
                v = 1'b0;
                if (after) begin
                    if (p >= 29 && p <= 36) v = pat[p - 29];
                    if (p >= 49 && p <= 56) v = pat[p - 49];
                end else begin
                    v = ((p >= 29 && p <= 36) || (p >= 49 && p <= 56));
                end
                exp_q.push_back(line_exp(nt, v));
                t = nt;
                step();
            end
        end
    endtask

    // Reset at pos 45 while pf is high: outputs and registers clear.
    task automatic test_reset_midline();
        out_t e;
        int   p;
        int   t;
        int   nt;
        logic after;
        logic v;
        t     = 0;
        after = 1'b0;
        do_reset();
        exp_q.push_back(line_exp(0, 1'b0));
        for (int c = 0; c <= 263; c++) begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                mismatched++;
                $display("[TB] FAIL reset_midline c=%0d actual=%h required=%h", c, obs, e);
            end
            compared++;
            if (c < 263) begin
                idle();
                nt = t + 1;
                if (c == 0) set_write(2'd0, 8'h10);
                if (c == 1) set_write(2'd1, 8'hFF);
                if (c == 182) begin
                    reset = 1'b1;
                    nt    = 0;
                    after = 1'b1;
                end
                p = (nt % 228) / 4;
                v = after ? 1'b0 :
                    (p == 17 || (p >= 21 && p <= 28) || p == 37 || (p >= 41 && p <= 48));
                exp_q.push_back(line_exp(nt, v));
                t = nt;
                step();
            end
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_timing();
        test_repeat();
        test_reflect();
        test_ref_midline();
        test_collision();
        test_rsync();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
